// File: rtl/mem_responder_if.sv
// Request/response bundle around mem_responder: CPU request lines, hit/load returns and the RAM port.
// The master side is the environment (datapath requesters plus the RAM model); the slave side is the responder.
interface mem_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Handshake: iREN / dREN / dWEN act as valid and are held by the requester until its
    // one-cycle ihit / dhit completion pulse. Requests are sampled only while the responder
    // is idle; a request dropped after sampling still completes and still pulses its hit.
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          ihit;
    logic          dhit;
    logic [DW-1:0] iload;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    dbg_state;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
        input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, dbg_state
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, dbg_state
    );
endinterface

// File: rtl/mem_responder.sv
// Arbitrates fetch and data requests onto a single-ported fixed-latency RAM and returns hit pulses.
// Optional macro MEM_RR_ARB_EN: round-robin between data and fetch instead of fixed data priority.
module mem_responder #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input logic            CLK,
    input logic            RST,
    mem_responder_if.slave bus
);
    localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          is_data_q,   is_data_d;
    logic          is_write_q,  is_write_d;
    logic          ihit_q,      ihit_d;
    logic          dhit_q,      dhit_d;
    logic [DW-1:0] iload_q,     iload_d;
    logic [DW-1:0] dload_q,     dload_d;
    logic          ram_ren_q,   ram_ren_d;
    logic          ram_wen_q,   ram_wen_d;
    logic [AW-1:0] ram_addr_q,  ram_addr_d;
    logic [DW-1:0] ram_store_q, ram_store_d;
`ifdef MEM_RR_ARB_EN
    logic          last_data_q, last_data_d;
`endif

    logic d_req;
    logic i_req;
    logic grant_data;
    logic grant_write;

    always_comb begin
        d_req = bus.dREN | bus.dWEN;
        i_req = bus.iREN;
`ifdef MEM_RR_ARB_EN
        // Under contention the side that lost last time wins; otherwise whoever asks.
        grant_data = d_req & (~i_req | ~last_data_q);
`else
        grant_data = d_req;
`endif
        // dREN together with dWEN is treated as a write.
        grant_write = grant_data & bus.dWEN;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_data_d   = is_data_q;
        is_write_d  = is_write_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        iload_d     = iload_q;
        dload_d     = dload_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
`ifdef MEM_RR_ARB_EN
        last_data_d = last_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_req | i_req) begin
                    state_d    = ACC;
                    cnt_d      = CNT_LOAD;
                    is_data_d  = grant_data;
                    is_write_d = grant_write;
                    ram_ren_d  = ~grant_write;
                    ram_wen_d  = grant_write;
                    ram_addr_d = grant_data ? bus.daddr : bus.iaddr;
                    if (grant_write) begin
                        ram_store_d = bus.dstore;
                    end
`ifdef MEM_RR_ARB_EN
                    last_data_d = grant_data;
`endif
                end
            end

            ACC: begin
                if (cnt_q == '0) begin
                    // Last access cycle: ramload is valid now, strobes drop with the hit.
                    state_d   = HIT;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    ihit_d    = ~is_data_q;
                    dhit_d    = is_data_q;
                    if (!is_write_q) begin
                        if (is_data_q) begin
                            dload_d = bus.ramload;
                        end else begin
                            iload_d = bus.ramload;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            HIT: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                ram_ren_d = 1'b0;
                ram_wen_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_data_q   <= 1'b0;
            is_write_q  <= 1'b0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            iload_q     <= '0;
            dload_q     <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
`ifdef MEM_RR_ARB_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_data_q   <= is_data_d;
            is_write_q  <= is_write_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            iload_q     <= iload_d;
            dload_q     <= dload_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
`ifdef MEM_RR_ARB_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    assign bus.ihit      = ihit_q;
    assign bus.dhit      = dhit_q;
    assign bus.iload     = iload_q;
    assign bus.dload     = dload_q;
    assign bus.ramREN    = ram_ren_q;
    assign bus.ramWEN    = ram_wen_q;
    assign bus.ramaddr   = ram_addr_q;
    assign bus.ramstore  = ram_store_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's instruction and data request lines. It accepts fetch and load/store requests and arbitrates them onto a single-ported RAM with a fixed access latency. It returns one-cycle `ihit`/`dhit` pulses with read data. It sits between the datapath request logic and the RAM model, and is the block that terminates the `dMemREN`/`dMemWEN` handshake.

## Interface
Parameters:
- `LAT`, 2, RAM access cycles per transaction; must be ≥1.
- `AW`, 32, address width.
- `DW`, 32, data width.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iREN`  in  1  instruction fetch request, held until `ihit`.
- `iaddr`  in  AW  fetch address.
- `dREN`  in  1  data read request, held until `dhit`.
- `dWEN`  in  1  data write request, held until `dhit`.
- `daddr`  in  AW  data address.
- `dstore`  in  DW  write data.
- `ihit`  out  1  one-cycle fetch completion pulse.
- `dhit`  out  1  one-cycle data completion pulse.
- `iload`  out  DW  fetched word; valid while `ihit`=1, held afterwards.
- `dload`  out  DW  read word; valid while `dhit`=1, held afterwards.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  AW  RAM address.
- `ramstore`  out  DW  RAM write data.
- `ramload`  in  DW  RAM read data, valid on the last access cycle.

## Operation
The state machine has three states: IDLE, ACC and HIT.
- **IDLE**
  - With no request pending, stay in IDLE.
  - Otherwise, at the edge, grant one requester. Data (`dREN|dWEN`) wins over `iREN`.
  - Latch the granted address and the operation. For a write, also latch `dstore`.
  - Load the counter `cnt` with `LAT-1` and go to ACC.
- **ACC**
  - `ramREN`/`ramWEN`, `ramaddr` and `ramstore` are driven from the latched values.
  - Decrement `cnt` each cycle.
  - At `cnt==0`: capture `ramload` into `iload` or `dload` (reads only), then go to HIT.
- **HIT**
  - Assert `ihit` or `dhit`, whichever matches the granted requester, for exactly one cycle.
  - Go to IDLE.

Rules:
- If `dREN` and `dWEN` are both high, the access is a write; `dload` is unchanged.
- A data write returns `dhit` with `dload` unchanged.
- Requests are sampled only in IDLE. Changes to a request during ACC/HIT are ignored. A dropped request still completes and still pulses its hit.
- `ihit` and `dhit` are never high in the same cycle.
- The RAM strobes are low in every state except ACC.
- The counter is wide enough to hold `LAT-1`; it never wraps below 0.

## Timing
- Reset: state=IDLE, `cnt`=0.
- All outputs reset to 0: `ihit`, `dhit`, `iload`, `dload`, `ramREN`, `ramWEN`, `ramaddr`, `ramstore`.
- If a request is high in IDLE at cycle 0:
  - ACC occupies cycles 1..LAT.
  - The hit pulse occurs in cycle LAT+1.
  - IDLE resumes in cycle LAT+2.
- Throughput: one transaction per LAT+2 cycles, including the IDLE sample cycle.
- Back-to-back: a requester still high in the cycle after its hit is re-sampled in IDLE and starts a new transaction. This is normal for fetch streams.
- Reset mid-operation (ACC or HIT): at the next edge go to IDLE. No hit is issued, and the RAM strobes drop in that same edge's outputs.
- Outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `MEM_RR_ARB_EN` defined:
  - When data and instruction requests are both pending in IDLE, the requester not granted last time wins.
  - A 1-bit last-grant flag records the previous grant. It resets to "instruction", so data wins the first contention.
- `MEM_RR_ARB_EN` undefined: fixed data priority, with no last-grant flag.

## Test plan
- **Reset:** hold `RST`=1 for 2 cycles with `iREN`=1 → all outputs 0, no hit. Release → `ramREN`=1 in cycle 1 and `ihit`=1 in cycle 3 (LAT=2).
- **Fetch:** `iaddr`=0x40, RAM returns 0xDEADBEEF → `ihit` is a single 1-cycle pulse, `iload`=0xDEADBEEF, `ramaddr`=0x40 during ACC.
- **Contention:** `iREN`=`dREN`=1 continuously, no macro → `dhit` before `ihit`, with every data request served first. With `MEM_RR_ARB_EN` defined → grants alternate d, i, d, i.
- **Write:** `dWEN`=1, `daddr`=0x100, `dstore`=0x12345678 → `ramWEN`=1 for exactly LAT cycles with matching address/data, then `dhit` pulse, `dload` unchanged.
- **Reset mid-access:** assert `RST` in the second ACC cycle → next cycle all outputs 0, no `dhit`. A new request after release completes normally.
- **LAT=1 sweep:** run the fetch scenario with LAT=1 → hit in cycle 2, one ACC cycle.
